// File: rtl/eth_frame_arbiter.sv
// eth_frame_arbiter: merges NUM_IN framed word streams into one output stream.
// Whole frames are granted round-robin to sources presenting a start-of-frame
// word. The granted source is passed straight through with no added latency.
// Orphan words seen while idle are discarded and counted. A frame that is
// restarted mid-way, or that runs longer than MAX_WORDS, is closed early.
module eth_frame_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN-1:0]          in_sop,
  input  logic [NUM_IN-1:0]          in_eop,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(NUM_IN)-1:0]  out_src,
  output logic                       frame_err,
  output logic [15:0]                drop_cnt
);

  localparam int SRC_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_WORDS - 1);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_IN - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   grant, last_grant, winner;
  logic               any_req;
  logic [CNT_W-1:0]   beat_cnt;
  logic [NUM_IN-1:0]  req, orphan;
  logic               sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic               out_fire, force_eop, abort;
  logic [3:0]         drop_inc;
  logic [16:0]        drop_sum;
  logic [15:0]        drop_nxt;

  assign req     = in_valid & in_sop;
  assign orphan  = in_valid & ~in_sop;
  assign out_src = grant;

  // Round-robin pick: first requester found searching upward from last_grant+1.
  always_comb begin
    int idx;
    logic [SRC_W-1:0] cand;
    winner  = last_grant;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      cand = SRC_W'(idx);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Select the fields of the currently granted source.
  always_comb begin
    sel_valid = in_valid[grant];
    sel_sop   = in_sop[grant];
    sel_eop   = in_eop[grant];
    sel_data  = in_data[int'(grant)*DATA_W +: DATA_W];
  end

  // Saturating sum of the orphan words discarded this cycle.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (orphan[i]) drop_inc = drop_inc + 4'd1;
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Next-state and output decode; everything is held low while in reset.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    frame_err = 1'b0;
    abort     = 1'b0;
    force_eop = 1'b0;
    out_fire  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          in_ready = orphan;
          if (any_req) state_nxt = GRANT;
        end
        GRANT, XFER: begin
          abort = (state == XFER) && sel_valid && sel_sop;
          if (abort) begin
            out_valid = 1'b1;
            out_eop   = 1'b1;
            if (out_ready) begin
              frame_err = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            force_eop       = (beat_cnt == LAST_BEAT) && !sel_eop;
            out_valid       = sel_valid;
            out_sop         = sel_sop;
            out_eop         = sel_eop || force_eop;
            out_data        = sel_data;
            in_ready[grant] = out_ready;
            out_fire        = sel_valid && out_ready;
            if (out_fire) begin
              if (sel_eop || force_eop) begin
                frame_err = force_eop;
                state_nxt = IDLE;
              end else begin
                state_nxt = XFER;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, grant, beat counter and drop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_SRC;
      beat_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        drop_cnt <= drop_nxt;
        if (any_req) begin
          grant    <= winner;
          beat_cnt <= '0;
        end
      end
      if (out_fire) beat_cnt <= beat_cnt + 1'b1;
      if (state != IDLE && state_nxt == IDLE) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Directed bench for eth_frame_arbiter: per-source word queues drive the inputs,
// every output transfer is logged and compared against hand-built frame lists.
module tb_eth_frame_arbiter;

  localparam int NUM_IN    = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 16;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_IN-1:0]        in_valid, in_sop, in_eop, in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic                     out_valid, out_sop, out_eop, out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               out_src;
  logic                     frame_err;
  logic [15:0]              drop_cnt;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  src;
    int          cyc;
  } out_t;

  word_t             src_q [NUM_IN][$];
  out_t              out_log[$];
  out_t              exp_q[$];
  logic [NUM_IN-1:0] fire;
  int                checks, failures, err_pulses, cycle, mirror_bad;
  bit                mirror_en, toggle_mode;

  eth_frame_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_ready(out_ready), .out_src(out_src),
    .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mkData(input int src, input int frm, input int w);
    return (32'(src) << 28) | (32'(frm) << 16) | 32'(w);
  endfunction

  task automatic pushFrame(input int src, input int frm, input int n);
    word_t w;
    for (int i = 1; i <= n; i++) begin
      w.data = mkData(src, frm, i);
      w.sop  = (i == 1);
      w.eop  = (i == n);
      src_q[src].push_back(w);
    end
  endtask

  task automatic expFrame(input int src, input int frm, input int n);
    out_t o;
    for (int i = 1; i <= n; i++) begin
      o.data = mkData(src, frm, i);
      o.sop  = (i == 1);
      o.eop  = (i == n);
      o.src  = 2'(src);
      o.cyc  = 0;
      exp_q.push_back(o);
    end
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (!allEmpty() && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    checkOutput({tag, "_drain"}, 64'(n < budget), 64'd1);
  endtask

  task automatic checkLog(input string tag);
    int n;
    checkOutput({tag, "_len"}, 64'(out_log.size()), 64'(exp_q.size()));
    n = (out_log.size() < exp_q.size()) ? out_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_w%0d", tag, i),
                  {28'd0, out_log[i].src, out_log[i].sop, out_log[i].eop, out_log[i].data},
                  {28'd0, exp_q[i].src, exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
    end
    out_log.delete();
    exp_q.delete();
  endtask

  task automatic applyStimulus(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    repeat (cycles) step();
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_eop",   64'(out_eop),   64'd0);
    checkOutput("rst_out_data",  64'(out_data),  64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    checkOutput("rst_out_src",   64'(out_src),   64'd0);
    checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    err_pulses = 0;
  endtask

  // Source driver and output monitor: sample handshakes at negedge, update after posedge.
  initial begin
    word_t tmp;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cycle++;
      fire = in_valid & in_ready;
      if (out_valid && out_ready) begin
        out_t o;
        o.data = out_data; o.sop = out_sop; o.eop = out_eop; o.src = out_src; o.cyc = cycle;
        out_log.push_back(o);
      end
      if (frame_err) err_pulses++;
      if (mirror_en && out_valid && out_src == 2'd3 && (in_ready[3] !== out_ready)) mirror_bad++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (fire[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          in_valid[i] = 1'b1;
          in_sop[i]   = src_q[i][0].sop;
          in_eop[i]   = src_q[i][0].eop;
          in_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
        end else begin
          in_valid[i] = 1'b0;
          in_sop[i]   = 1'b0;
          in_eop[i]   = 1'b0;
          in_data[i*DATA_W +: DATA_W] = '0;
        end
      end
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int n, eop_seen;
    bit all_src2;
    checks = 0; failures = 0; err_pulses = 0; cycle = 0; mirror_bad = 0;
    mirror_en = 1'b0; toggle_mode = 1'b0;
    rst_n = 1'b0;
    applyStimulus(3);

    // Sources 0 and 2 start together: source 0 first, one idle bubble, then 2.
    pushFrame(0, 1, 16); pushFrame(2, 1, 16);
    expFrame(0, 1, 16);  expFrame(2, 1, 16);
    waitIdle("s1", 300);
    if (out_log.size() >= 17) checkOutput("s1_bubble", 64'(out_log[16].cyc - out_log[15].cyc), 64'd2);
    else checkOutput("s1_bubble_len", 64'(out_log.size()), 64'd32);
    checkLog("s1");
    checkOutput("s1_err", 64'(err_pulses), 64'd0);

    // All four sources stream three frames each: grants cycle 0,1,2,3.
    applyStimulus(2);
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < NUM_IN; s++) pushFrame(s, f + 2, 16);
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < NUM_IN; s++) expFrame(s, f + 2, 16);
    waitIdle("s2", 1000);
    checkLog("s2");
    checkOutput("s2_err", 64'(err_pulses), 64'd0);

    // Overlength 20-word frame: eop forced on word 16, words 17..20 dropped.
    applyStimulus(2);
    pushFrame(1, 5, 20);
    expFrame(1, 5, 16);
    waitIdle("s3", 300);
    checkLog("s3");
    checkOutput("s3_err", 64'(err_pulses), 64'd1);
    checkOutput("s3_drop", 64'(drop_cnt), 64'd4);

    // Backpressure toggling every cycle on a source 3 frame.
    applyStimulus(2);
    mirror_bad = 0; mirror_en = 1'b1; toggle_mode = 1'b1;
    pushFrame(3, 7, 16);
    expFrame(3, 7, 16);
    waitIdle("s4", 300);
    mirror_en = 1'b0; toggle_mode = 1'b0;
    checkLog("s4");
    checkOutput("s4_mirror", 64'(mirror_bad), 64'd0);
    checkOutput("s4_err", 64'(err_pulses), 64'd0);

    // Single-word frames, then reset in the middle of a source 2 frame.
    applyStimulus(2);
    pushFrame(0, 8, 1); pushFrame(1, 8, 1);
    expFrame(0, 8, 1);  expFrame(1, 8, 1);
    waitIdle("s5a", 100);
    checkLog("s5a");
    pushFrame(2, 9, 16);
    n = 0;
    while (out_log.size() < 5 && n < 100) begin
      step();
      n++;
    end
    checkOutput("s5_midframe_wait", 64'(n < 100), 64'd1);
    applyStimulus(2);
    eop_seen = 0;
    all_src2 = 1'b1;
    foreach (out_log[i]) begin
      if (out_log[i].eop) eop_seen++;
      if (out_log[i].src != 2'd2) all_src2 = 1'b0;
    end
    checkOutput("s5_abandon_no_eop", 64'(eop_seen), 64'd0);
    checkOutput("s5_abandon_src", 64'(all_src2), 64'd1);
    checkOutput("s5_abandon_len", 64'(out_log.size() >= 5 && out_log.size() < 16), 64'd1);
    out_log.delete();
    step();
    @(negedge clk);
    checkOutput("s5_post_valid", 64'(out_valid), 64'd0);
    checkOutput("s5_post_drop", 64'(drop_cnt), 64'd0);
    step();
    pushFrame(3, 10, 1); pushFrame(1, 10, 1);
    expFrame(1, 10, 1);  expFrame(3, 10, 1);
    waitIdle("s5c", 100);
    checkLog("s5c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_frame_arbiter.md
ETH_FRAME_ARBITER -- requirements
Module: eth_frame_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of frame sources (2..8).
REQ-002 Parameter DATA_W, default 32, word width of every stream.
REQ-003 Parameter MAX_WORDS, default 16, longest legal frame in words.
REQ-004 clk  input  1  sole clock, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  NUM_IN  per-source word valid.
REQ-007 in_sop  input  NUM_IN  per-source start-of-frame, qualified by in_valid.
REQ-008 in_eop  input  NUM_IN  per-source end-of-frame, qualified by in_valid.
REQ-009 in_data  input  NUM_IN*DATA_W  per-source word; source i at bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  output  NUM_IN  per-source accept; a word transfers when in_valid[i] and in_ready[i] are both high.
REQ-011 out_valid, out_sop, out_eop  output  1 each  merged stream framing.
REQ-012 out_data  output  DATA_W  merged stream word.
REQ-013 out_ready  input  1  downstream accept; output word transfers when out_valid and out_ready are both high.
REQ-014 out_src  output  clog2(NUM_IN)  index of the source owning the current frame.
REQ-015 frame_err  output  1  one-cycle pulse on forced frame termination.
REQ-016 drop_cnt  output  16  saturating count of discarded orphan words.

Function
REQ-017 FSM states: IDLE, GRANT, XFER.
REQ-018 IDLE: arbitration over requests req[i] = in_valid[i] & in_sop[i]; round-robin, search starts at last_grant+1 modulo NUM_IN.
REQ-019 IDLE with any request: winner latched into grant register; out_src loads it; next state GRANT. One-cycle arbitration bubble; out_valid low in IDLE.
REQ-020 IDLE with no request: remain IDLE.
REQ-021 Orphans in IDLE: in_ready[i] high for every source with in_valid[i] & ~in_sop[i]; word discarded; drop_cnt += number of such sources that cycle; saturates at 0xFFFF.
REQ-022 GRANT and XFER are pass-through for granted source g: out_valid = in_valid[g], out_data/out_sop/out_eop = source g fields, in_ready[g] = out_ready; all other in_ready low. Zero added latency.
REQ-023 GRANT moves to XFER on the first output transfer (source g sop word).
REQ-024 Beat counter clears on entry to GRANT; increments per output transfer; width clog2(MAX_WORDS+1).
REQ-025 Frame end: output transfer with out_eop high -> last_grant <= g, next state IDLE.
REQ-026 Single-word frame (sop and eop on same word) is legal: GRANT -> IDLE directly, counter unaffected otherwise.
REQ-027 Word with in_sop high at source g while in XFER: not forwarded; arbiter drives out_valid high, out_eop high, out_data 0, in_ready[g] low; frame_err pulses when that word transfers; next state IDLE; source g's sop word stays pending and re-arbitrates.
REQ-028 Overlength: transfer number MAX_WORDS without eop -> out_eop forced high on that word, frame_err pulses, next state IDLE; following source g words are orphans per REQ-021.
REQ-029 out_ready low holds all state; no word lost or duplicated; out_data and framing stable while out_valid & ~out_ready.
REQ-030 Sources not granted see in_ready low; their pending sop words wait without loss.
REQ-031 Fairness: with all sources continuously requesting, grant order is strictly cyclic; no source waits more than NUM_IN-1 frames.

Reset
REQ-032 rst_n low at a clock edge: state IDLE, last_grant = NUM_IN-1 (source 0 wins first), out_src 0, beat counter 0, drop_cnt 0, frame_err 0.
REQ-033 During and after reset until IDLE decisions: out_valid, out_sop, out_eop, in_ready all 0 and out_data 0; reset mid-frame abandons the frame with no eop emitted.

Verification
REQ-034 Sources 0 and 2 raise sop together after reset, 16-word frames -> source 0 frame on output (out_src=0), one bubble, then source 2 (out_src=2); words intact, in order.
REQ-035 All 4 sources streaming back-to-back 16-word frames for 12 frames -> grant sequence 0,1,2,3 repeating; every frame 16 words; frame_err never pulses.
REQ-036 Source 1 frame of 20 words, no eop until word 20 -> output word 16 has out_eop=1, frame_err pulses once; words 17-20 discarded, drop_cnt = 4.
REQ-037 out_ready toggled 1010... during a frame from source 3 -> output sequence identical to source input; in_ready[3] mirrors out_ready; no duplicates.
REQ-038 Single-word frames (sop=eop=1) from sources 0 and 1, then rst_n low mid-frame of source 2 -> two 1-word frames output; after reset out_valid 0, drop_cnt 0, next grant goes to lowest requesting index.
